// File: rtl/z1_to_zm_pkg.sv
// Shared constants and helpers for the polyphase input deinterleaver.
package z1_to_zm_pkg;

  localparam int DEF_W = 11;
  localparam int DEF_M = 3;

  typedef logic signed [DEF_W-1:0] sample_t;

  function automatic int cnt_width(input int m);
    return $clog2(m);
  endfunction

endpackage

// File: rtl/z1_to_zm_deinterleave_tap_line.sv
// Enable-gated shift register holding the most recent N accepted samples.
module zm_tap_line #(
  parameter int W = 11,
  parameter int N = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic signed [W-1:0] d,
  output logic signed [W-1:0] taps [0:N-1]
);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N; k++) taps[k] <= '0;
    end else if (en) begin
      taps[0] <= d;
      for (int k = 1; k < N; k++) taps[k] <= taps[k-1];
    end
  end

endmodule

// File: rtl/z1_to_zm_deinterleave.sv
// Collects M accepted samples into one registered M-lane frame (Out[0] newest).
// Optional sticky phase_err output enabled by defining Z1TOZM_PHASE_ERR_EN.
module z1_to_zm_deinterleave
  import z1_to_zm_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int M = DEF_M
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_vld,
  input  logic                sync,
  input  logic signed [W-1:0] In,
  output logic signed [W-1:0] Out [0:M-1],
  output logic                out_vld
`ifdef Z1TOZM_PHASE_ERR_EN
  ,
  output logic                phase_err
`endif
);

  localparam int CW = cnt_width(M);
  localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

  logic [CW-1:0]       cnt;
  logic signed [W-1:0] taps [0:M-2];
  logic                frame_done;

  // A sync sample is phase 0, so it can never complete a frame.
  assign frame_done = in_vld && !sync && (cnt == CNT_LAST);

  zm_tap_line #(
    .W (W),
    .N (M - 1)
  ) u_tap_line (
    .clk   (clk),
    .reset (reset),
    .en    (in_vld),
    .d     (In),
    .taps  (taps)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (in_vld) begin
      if (sync)
        cnt <= CW'(1);
      else if (cnt == CNT_LAST)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld <= 1'b0;
      for (int k = 0; k < M; k++) Out[k] <= '0;
    end else begin
      out_vld <= frame_done;
      if (frame_done) begin
        Out[0] <= In;
        for (int k = 1; k < M; k++) Out[k] <= taps[k-1];
      end
    end
  end

`ifdef Z1TOZM_PHASE_ERR_EN
  always_ff @(posedge clk) begin
    if (reset)
      phase_err <= 1'b0;
    else if (in_vld && sync && (cnt != '0))
      phase_err <= 1'b1;
  end
`endif

endmodule
